// File: rtl/aes_crypt_arbiter_if.sv
// Requester and response bus between two plaintext sources, one consumer and the
// shared AES arbiter. The master side is the requesters plus the consumer.
interface aes_crypt_arbiter_if;
    logic         req0_valid;
    logic         req0_ready;
    logic [127:0] req0_data;
    logic         req1_valid;
    logic         req1_ready;
    logic [127:0] req1_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_data;
    logic         rsp_id;
    logic         rsp_err;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );
endinterface

// File: rtl/aes_crypt_arbiter.sv
// Round-robin sharing of one aes_crypt core between two requesters, sequencing
// clear/trigger/wait on the core and returning a tagged ciphertext or a timeout error.
module aes_crypt_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    aes_crypt_arbiter_if.slave  bus,
    output logic                busy,
    output logic                core_reset,
    output logic                core_trigger,
    output logic [127:0]        core_in,
    input  logic                core_done,
    input  logic [127:0]        core_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_TRIG,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [7:0] LP_LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    state_t       r_state;
    state_t       w_nextState;
    logic         r_last;
    logic [7:0]   r_count;
    logic [127:0] r_plain;
    logic [127:0] r_rspData;
    logic         r_rspId;
    logic         r_rspErr;

    logic         w_grant0;
    logic         w_grant1;
    logic         w_accept;
    logic         w_timeout;

    // On a tie the requester that was not served last wins.
    assign w_grant0  = bus.req0_valid && (!bus.req1_valid || r_last);
    assign w_grant1  = bus.req1_valid && (!bus.req0_valid || !r_last);
    assign w_accept  = (r_state == S_IDLE) && !reset && (w_grant0 || w_grant1);
    assign w_timeout = (r_count == LP_LAST_COUNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_nextState = S_CLR;
            S_CLR:   w_nextState = S_TRIG;
            S_TRIG:  w_nextState = S_WAIT;
            S_WAIT:  if (core_done || w_timeout) w_nextState = S_RESP;
            S_RESP:  if (bus.rsp_ready) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last    <= 1'b1;
            r_count   <= 8'd0;
            r_plain   <= '0;
            r_rspData <= '0;
            r_rspId   <= 1'b0;
            r_rspErr  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_plain <= w_grant1 ? bus.req1_data : bus.req0_data;
                        r_rspId <= w_grant1;
                        r_last  <= w_grant1;
                    end
                end
                S_TRIG: r_count <= 8'd0;
                S_WAIT: begin
                    // done takes priority over the watchdog on the final cycle
                    if (core_done) begin
                        r_rspData <= core_out;
                        r_rspErr  <= 1'b0;
                    end else if (w_timeout) begin
                        r_rspData <= '0;
                        r_rspErr  <= 1'b1;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = (r_state == S_IDLE) && !reset && w_grant0;
    assign bus.req1_ready = (r_state == S_IDLE) && !reset && w_grant1;
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_data   = r_rspData;
    assign bus.rsp_id     = r_rspId;
    assign bus.rsp_err    = r_rspErr;

    assign busy         = (r_state != S_IDLE);
    assign core_reset   = reset || (r_state == S_CLR);
    assign core_trigger = (r_state == S_TRIG);
    assign core_in      = r_plain;

endmodule
